// File: rtl/usb_da_frame_cache.sv
// usb_da_frame_cache
// Single-clock circular sample cache between the USB3 slave-FIFO read path
// and the DA outputs. Words are accepted while the USB read FSM sits in its
// active read state, the cache prefills to a watermark, then CH_N
// channel-interleaved words (ch0 first) are drained per DA sample tick into a
// CH_N-lane output register that is updated as one frame.
//
// Ports:
//   clock         system clock, all logic on posedge
//   rst           asynchronous active-high reset
//   flush         synchronous clear of pointers, level, divider and FSM
//                 (overflow and underrun_cnt are kept)
//   usb_rd_state  USB read FSM state; writes accepted only in RD_ACTIVE
//   usb_flaga     FX3 FLAGA, 0 = no more data on the USB side
//   wr_en/wr_data write strobe and word
//   da_data       CH_N lanes, lane k = bits [k*DATA_W +: DATA_W]
//   da_update     1-cycle pulse when da_data takes a new frame
//   usb_afull     registered back-pressure, fill_level >= AFULL_LVL
//   fill_level    words stored, 0..DEPTH
//   overflow      sticky, write attempted while full
//   underrun_cnt  saturating count of underrun entries
//   streaming     1 while the FSM is in STREAM
//
// Build option: define DA_UNDERRUN_MIDSCALE_EN to load DA midscale into every
// lane (with one da_update pulse) on underrun; otherwise the last frame holds.
// DA_DIV >= CH_N+2 is required so a frame sequence ends before the next tick.

module usb_da_frame_cache #(
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned ADDR_W      = 9,
    parameter int unsigned CH_N        = 2,
    parameter int unsigned DA_DIV      = 10,
    parameter int unsigned PREFILL_LVL = 256,
    parameter int unsigned AFULL_LVL   = 480,
    parameter logic [3:0]  RD_ACTIVE   = 4'd6
) (
    input  logic                     clock,
    input  logic                     rst,
    input  logic                     flush,
    input  logic [3:0]               usb_rd_state,
    input  logic                     usb_flaga,
    input  logic                     wr_en,
    input  logic [DATA_W-1:0]        wr_data,
    output logic [CH_N*DATA_W-1:0]   da_data,
    output logic                     da_update,
    output logic                     usb_afull,
    output logic [ADDR_W:0]          fill_level,
    output logic                     overflow,
    output logic [15:0]              underrun_cnt,
    output logic                     streaming
);

    localparam int unsigned DEPTH = 1 << ADDR_W;
    localparam int unsigned DIV_W = (DA_DIV > 1) ? $clog2(DA_DIV) : 1;
    localparam int unsigned SEQ_W = $clog2(CH_N + 2);

    localparam logic [ADDR_W:0]  LVL_FULL    = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]  LVL_PREFILL = (ADDR_W+1)'(PREFILL_LVL);
    localparam logic [ADDR_W:0]  LVL_AFULL   = (ADDR_W+1)'(AFULL_LVL);
    localparam logic [ADDR_W:0]  LVL_FRAME   = (ADDR_W+1)'(CH_N);
    localparam logic [DIV_W-1:0] DIV_LAST    = DIV_W'(DA_DIV - 1);
    localparam logic [SEQ_W-1:0] SEQ_POP_END = SEQ_W'(CH_N);
    localparam logic [SEQ_W-1:0] SEQ_LAST    = SEQ_W'(CH_N + 1);
`ifdef DA_UNDERRUN_MIDSCALE_EN
    localparam logic [DATA_W-1:0] MIDSCALE   = {1'b1, {(DATA_W-1){1'b0}}};
`endif

    typedef enum logic [1:0] {
        S_IDLE,
        S_PREFILL,
        S_STREAM,
        S_UNDERRUN
    } state_t;

    state_t state_q, state_d;

    logic [DATA_W-1:0]          mem [DEPTH];
    logic [DATA_W-1:0]          rd_data;
    logic [ADDR_W-1:0]          wr_ptr, rd_ptr;
    logic [DIV_W-1:0]           div;
    logic [SEQ_W-1:0]           seq;      // 0 = idle, s = cycle t+s after tick
    logic [CH_N*DATA_W-1:0]     shadow, shadow_shift;
    logic [(CH_N+1)*DATA_W-1:0] shift_cat;
    logic [ADDR_W:0]            level_next;
    logic                       tick, full, wr_active, wr_accept, pop;
    logic                       start_pop, underrun_hit;

    assign tick      = (div == DIV_LAST);
    assign full      = (fill_level == LVL_FULL);
    assign wr_active = wr_en && (usb_rd_state == RD_ACTIVE);
    assign wr_accept = wr_active && !full && !flush;
    assign pop       = (seq != '0) && (seq <= SEQ_POP_END) && !flush;
    assign streaming = (state_q == S_STREAM);

    // Words arrive ch0 first; shifting each new word in from the top leaves
    // word k in lane k after CH_N shifts.
    assign shift_cat    = {rd_data, shadow};
    assign shadow_shift = shift_cat[(CH_N+1)*DATA_W-1:DATA_W];

    always_comb begin
        level_next = fill_level;
        if (wr_accept && !pop)
            level_next = fill_level + 1'b1;
        else if (!wr_accept && pop)
            level_next = fill_level - 1'b1;
    end

    always_comb begin
        state_d      = state_q;
        start_pop    = 1'b0;
        underrun_hit = 1'b0;
        case (state_q)
            S_IDLE:
                if (wr_accept) state_d = S_PREFILL;
            S_PREFILL:
                if (fill_level >= LVL_PREFILL ||
                    (!usb_flaga && fill_level >= LVL_FRAME))
                    state_d = S_STREAM;
            S_STREAM:
                if (tick) begin
                    if (fill_level >= LVL_FRAME) begin
                        start_pop = 1'b1;
                    end else begin
                        underrun_hit = 1'b1;
                        state_d      = S_UNDERRUN;
                    end
                end
            S_UNDERRUN:
                state_d = S_PREFILL;
            default:
                state_d = S_IDLE;
        endcase
        if (flush) begin
            state_d      = S_IDLE;
            start_pop    = 1'b0;
            underrun_hit = 1'b0;
        end
    end

    // Storage: no reset, registered read of the word at rd_ptr every cycle.
    always_ff @(posedge clock) begin
        if (wr_accept)
            mem[wr_ptr] <= wr_data;
        rd_data <= mem[rd_ptr];
    end

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            div          <= '0;
            seq          <= '0;
            shadow       <= '0;
            fill_level   <= '0;
            usb_afull    <= 1'b0;
            da_data      <= '0;
            da_update    <= 1'b0;
            overflow     <= 1'b0;
            underrun_cnt <= '0;
        end else if (flush) begin
            state_q    <= S_IDLE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            div        <= '0;
            seq        <= '0;
            shadow     <= '0;
            fill_level <= '0;
            usb_afull  <= 1'b0;
            da_data    <= '0;
            da_update  <= 1'b0;
        end else begin
            state_q    <= state_d;
            div        <= tick ? '0 : div + 1'b1;
            fill_level <= level_next;
            usb_afull  <= (level_next >= LVL_AFULL);
            da_update  <= 1'b0;
            if (wr_accept)
                wr_ptr <= wr_ptr + 1'b1;
            if (wr_active && full)
                overflow <= 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;

            // Pops run at seq 1..CH_N, read data lands at seq 2..CH_N+1. The
            // last word goes straight into da_data with the shadow lanes so
            // the frame is visible CH_N+2 cycles after the tick.
            if (start_pop) begin
                seq <= SEQ_W'(1);
            end else if (seq != '0) begin
                if (seq >= SEQ_W'(2))
                    shadow <= shadow_shift;
                if (seq == SEQ_LAST) begin
                    da_data   <= shadow_shift;
                    da_update <= 1'b1;
                    seq       <= '0;
                end else begin
                    seq <= seq + 1'b1;
                end
            end

            if (underrun_hit) begin
                if (underrun_cnt != 16'hFFFF)
                    underrun_cnt <= underrun_cnt + 16'd1;
`ifdef DA_UNDERRUN_MIDSCALE_EN
                da_data   <= {CH_N{MIDSCALE}};
                da_update <= 1'b1;
`endif
            end
        end
    end

endmodule

// File: tb/tb_usb_da_frame_cache.sv
// Directed testbench for usb_da_frame_cache (DATA_W=32, ADDR_W=9, CH_N=2,
// DA_DIV=10, PREFILL_LVL=256, AFULL_LVL=480, RD_ACTIVE=6). Inputs change on
// the falling edge, outputs are sampled on the falling edge.

module tb_usb_da_frame_cache;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic [3:0]  usb_rd_state = 4'd0;
    logic        usb_flaga = 1'b1;
    logic        wr_en = 1'b0;
    logic [31:0] wr_data = '0;
    logic [63:0] da_data;
    logic        da_update;
    logic        usb_afull;
    logic [9:0]  fill_level;
    logic        overflow;
    logic [15:0] underrun_cnt;
    logic        streaming;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

`ifdef DA_UNDERRUN_MIDSCALE_EN
    localparam logic [63:0] EXP_UR_DATA = {32'h8000_0000, 32'h8000_0000};
    localparam int          EXP_UR_UPD  = 1;
`else
    localparam logic [63:0] EXP_UR_DATA = {32'd256, 32'd255};
    localparam int          EXP_UR_UPD  = 0;
`endif

    usb_da_frame_cache #(
        .DATA_W(32), .ADDR_W(9), .CH_N(2), .DA_DIV(10),
        .PREFILL_LVL(256), .AFULL_LVL(480), .RD_ACTIVE(4'd6)
    ) dut (
        .clock(clk), .rst(rst), .flush(flush),
        .usb_rd_state(usb_rd_state), .usb_flaga(usb_flaga),
        .wr_en(wr_en), .wr_data(wr_data),
        .da_data(da_data), .da_update(da_update), .usb_afull(usb_afull),
        .fill_level(fill_level), .overflow(overflow),
        .underrun_cnt(underrun_cnt), .streaming(streaming)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic do_reset();
        rst = 1'b1; flush = 1'b0; wr_en = 1'b0; usb_rd_state = 4'd0;
        usb_flaga = 1'b1; wr_data = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic write_seq(input int first, input int n);
        usb_rd_state = 4'd6;
        for (int i = 0; i < n; i++) begin
            wr_en = 1'b1; wr_data = 32'(first + i);
            @(negedge clk);
        end
        wr_en = 1'b0;
    endtask

    // which: 0 = da_update, 1 = streaming high, 2 = streaming low
    task automatic wait_sig(input int which, input int limit, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if ((which == 0 && da_update) || (which == 1 && streaming) ||
                (which == 2 && !streaming)) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if (da_data !== 64'd0) begin
            bad++; $display("FAIL reset_da_data: got %h expected 0", da_data);
        end
        total++;
        if (fill_level !== 10'd0) begin
            bad++; $display("FAIL reset_fill: got %0d expected 0", fill_level);
        end
        total++;
        if ({da_update, usb_afull, overflow, streaming, underrun_cnt} !== 20'd0) begin
            bad++; $display("FAIL reset_flags: got upd=%b afull=%b ovf=%b str=%b ur=%0d expected all 0",
                            da_update, usb_afull, overflow, streaming, underrun_cnt);
        end
    endtask

    task automatic test_ignore_state();
        logic [3:0] states [3] = '{4'd0, 4'd5, 4'd7};
        do_reset();
        foreach (states[s]) begin
            usb_rd_state = states[s];
            wr_en = 1'b1;
            for (int i = 0; i < 10; i++) begin
                wr_data = 32'(i + 1);
                @(negedge clk);
            end
            total++;
            if (fill_level !== 10'd0 || streaming !== 1'b0) begin
                bad++; $display("FAIL ignore_state%0d: got level=%0d str=%b expected 0/0",
                                states[s], fill_level, streaming);
            end
        end
        wr_en = 1'b0;
    endtask

    task automatic test_stream_underrun();
        bit ok;
        int last_upd;
        int upd_seen;
        do_reset();
        write_seq(1, 256);
        total++;
        if (fill_level !== 10'd256 || streaming !== 1'b0) begin
            bad++; $display("FAIL prefill_level: got level=%0d str=%b expected 256/0",
                            fill_level, streaming);
        end
        wait_sig(1, 5, ok);
        total++;
        if (!ok) begin
            bad++; $display("FAIL stream_start: got streaming=0 expected 1");
        end
        last_upd = 0;
        for (int f = 0; f < 128 && ok; f++) begin
            wait_sig(0, 20, ok);
            total++;
            if (!ok) begin
                bad++; $display("FAIL frame_wait%0d: got no da_update expected one", f);
            end else begin
                total++;
                if (da_data !== {32'(2*f + 2), 32'(2*f + 1)}) begin
                    bad++; $display("FAIL frame%0d: got %h expected %h",
                                    f, da_data, {32'(2*f + 2), 32'(2*f + 1)});
                end
                if (f > 0) begin
                    total++;
                    if (cyc - last_upd != 10) begin
                        bad++; $display("FAIL frame_spacing%0d: got %0d expected 10",
                                        f, cyc - last_upd);
                    end
                end
                last_upd = cyc;
            end
        end
        total++;
        if (fill_level !== 10'd0) begin
            bad++; $display("FAIL drained_level: got %0d expected 0", fill_level);
        end
        upd_seen = 0;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (da_update) upd_seen++;
            if (!streaming) begin ok = 1'b1; break; end
        end
        total++;
        if (!ok) begin
            bad++; $display("FAIL underrun_wait: got streaming=1 expected 0");
        end
        total++;
        if (underrun_cnt !== 16'd1) begin
            bad++; $display("FAIL underrun_cnt: got %0d expected 1", underrun_cnt);
        end
        total++;
        if (da_data !== EXP_UR_DATA || upd_seen != EXP_UR_UPD) begin
            bad++; $display("FAIL underrun_data: got %h upd=%0d expected %h upd=%0d",
                            da_data, upd_seen, EXP_UR_DATA, EXP_UR_UPD);
        end
        repeat (3) @(negedge clk);
        total++;
        if (streaming !== 1'b0 || underrun_cnt !== 16'd1) begin
            bad++; $display("FAIL underrun_stays_prefill: got str=%b ur=%0d expected 0/1",
                            streaming, underrun_cnt);
        end
    endtask

    task automatic test_async_reset();
        bit ok;
        do_reset();
        write_seq(1, 256);
        wait_sig(0, 40, ok);
        total++;
        if (!ok || streaming !== 1'b1) begin
            bad++; $display("FAIL pre_rst_stream: got upd_ok=%b str=%b expected 1/1", ok, streaming);
        end
        #1 rst = 1'b1;
        #1;
        total++;
        if ({da_data, da_update, usb_afull, fill_level, overflow, underrun_cnt, streaming} !== '0) begin
            bad++; $display("FAIL async_rst: got data=%h lvl=%0d str=%b upd=%b expected all 0",
                            da_data, fill_level, streaming, da_update);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_overflow_flush();
        bit reached;
        do_reset();
        usb_rd_state = 4'd6;
        wr_en = 1'b1;
        reached = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            wr_data = 32'(i + 1);
            @(negedge clk);
            total++;
            if (usb_afull !== (fill_level >= 10'd480)) begin
                bad++; $display("FAIL afull_at%0d: got %b expected %b",
                                fill_level, usb_afull, fill_level >= 10'd480);
            end
            if (fill_level == 10'd512) begin reached = 1'b1; break; end
            total++;
            if (overflow !== 1'b0) begin
                bad++; $display("FAIL early_overflow: got 1 expected 0 at level %0d", fill_level);
            end
        end
        total++;
        if (!reached) begin
            bad++; $display("FAIL reach_full: got level=%0d expected 512", fill_level);
        end
        @(negedge clk);
        total++;
        if (overflow !== 1'b1 || usb_afull !== 1'b1) begin
            bad++; $display("FAIL overflow: got ovf=%b afull=%b expected 1/1", overflow, usb_afull);
        end
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        wr_en = 1'b0;
        total++;
        if (fill_level !== 10'd0 || overflow !== 1'b1 || streaming !== 1'b0 ||
            da_data !== 64'd0 || usb_afull !== 1'b0) begin
            bad++; $display("FAIL flush: got lvl=%0d ovf=%b str=%b data=%h afull=%b expected 0/1/0/0/0",
                            fill_level, overflow, streaming, da_data, usb_afull);
        end
    endtask

    task automatic test_flaga_tail();
        bit ok;
        do_reset();
        usb_flaga = 1'b0;
        write_seq(1, 3);
        wait_sig(0, 40, ok);
        total++;
        if (!ok || da_data !== {32'd2, 32'd1} || streaming !== 1'b1) begin
            bad++; $display("FAIL tail_frame: got ok=%b data=%h str=%b expected 1/%h/1",
                            ok, da_data, streaming, {32'd2, 32'd1});
        end
        wait_sig(2, 20, ok);
        total++;
        if (!ok || underrun_cnt !== 16'd1 || fill_level !== 10'd1) begin
            bad++; $display("FAIL tail_underrun: got ok=%b ur=%0d lvl=%0d expected 1/1/1",
                            ok, underrun_cnt, fill_level);
        end
        usb_flaga = 1'b1;
    endtask

    // Writes are issued during the two pop cycles that follow each frame by
    // 7 and 8 clocks (tick + DA_DIV, pops at tick+1..tick+2, update at tick+4).
    task automatic test_back_to_back();
        int  sent = 0;
        int  expv = 1;
        int  last_upd = -100;
        int  holds = 0;
        bit  hold_pending = 1'b0;
        bit  win, want;
        do_reset();
        usb_rd_state = 4'd6;
        for (int c = 0; c < 6000 && expv <= 600; c++) begin
            if (hold_pending) begin
                holds++;
                total++;
                if (fill_level !== 10'd300) begin
                    bad++; $display("FAIL hold300: got %0d expected 300", fill_level);
                end
                hold_pending = 1'b0;
            end
            if (da_update) begin
                total++;
                if (da_data !== {32'(expv + 1), 32'(expv)}) begin
                    bad++; $display("FAIL wrap_frame%0d: got %h expected %h",
                                    expv, da_data, {32'(expv + 1), 32'(expv)});
                end
                expv += 2;
                last_upd = cyc;
            end
            win  = (cyc == last_upd + 7) || (cyc == last_upd + 8);
            want = (sent < 600) && (fill_level < 10'd300 || win);
            hold_pending = want && win && (fill_level == 10'd300);
            wr_en   = want;
            wr_data = 32'(sent + 1);
            if (want) sent++;
            @(negedge clk);
        end
        wr_en = 1'b0;
        total++;
        if (expv != 601) begin
            bad++; $display("FAIL wrap_all_frames: got next=%0d expected 601", expv);
        end
        total++;
        if (holds == 0) begin
            bad++; $display("FAIL hold_seen: got 0 expected >0");
        end
    endtask

    initial begin
        test_reset();
        test_ignore_state();
        test_stream_underrun();
        test_async_reset();
        test_overflow_flush();
        test_flaga_tail();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
